sram_access_arbiter: RTL and testbench
======================================

// Module: sram_access_arbiter
// PURPOSE
//  Shares the single-port 128-bit test SRAM between two requesters: port 0 = AMBA slave side
//  (key/data writes, result reads), port 1 = cipher core side. Grants one whole access at a time.
//  Sequences each access as address setup, strobe, capture, then returns read data and a 1-cycle ack.
//  Sits between the AMBA interface FSM / cipher core and the SRAM model.
// PARAMETERS
//  ADDR_W         16   SRAM address width
//  DATA_W         128  SRAM data width
//  ACCESS_CYCLES  1    cycles read/write strobe is held high (legal 1..4)
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  n_rst       in   1       asynchronous, active-low reset
//  m0_req      in   1       port 0 request; held until m0_ack
//  m0_wr       in   1       port 0: 1 = write, 0 = read
//  m0_addr     in   ADDR_W  port 0 address
//  m0_wdata    in   DATA_W  port 0 write data
//  m0_ack      out  1       port 0 access complete (1-cycle pulse)
//  m0_rdata    out  DATA_W  port 0 read data, valid while m0_ack=1
//  m1_*        --   --      port 1, same set as m0_*
//  read        out  1       SRAM read strobe
//  write       out  1       SRAM write strobe
//  addr        out  ADDR_W  SRAM address
//  write_data  out  DATA_W  SRAM write data
//  read_data   in   DATA_W  SRAM read data, valid while read=1
//  busy        out  1       1 in any state other than IDLE
//  grant_id    out  1       port owning the current access; holds last value in IDLE
// BEHAVIOUR
//  Reset: state=IDLE; read=write=0; addr=0; write_data=0; m0/m1_ack=0; m0/m1_rdata=0; busy=0;
//   grant_id=0; last_grant=1; strobe counter=0. A reset mid-access abandons it; nothing is replayed.
//  States: IDLE -> SETUP -> ACCESS -> CAPTURE -> DONE -> IDLE.
//   IDLE: no strobes. If any req is high, pick the winner, latch its wr/addr/wdata into internal
//    registers, set grant_id, and go to SETUP.
//   SETUP (1 cycle): addr/write_data driven from latched values; strobes low.
//   ACCESS (ACCESS_CYCLES cycles): read=~wr or write=wr; addr/write_data stay stable.
//    The counter loads 0 on entry, increments each cycle, and leaves when it reaches ACCESS_CYCLES-1.
//   CAPTURE (1 cycle): strobes low. For a read, read_data sampled in the last ACCESS cycle
//    is already registered into the winner's rdata.
//   DONE (1 cycle): the winner's ack=1; the other port's ack stays 0; then IDLE.
//  Latency with ACCESS_CYCLES=1: req seen in IDLE at edge N; SETUP N+1, ACCESS N+2,
//   CAPTURE N+3, ack high N+4..N+5. Minimum spacing between grants is 5 cycles.
//  Requester rule: drop req in the cycle after ack, or keep it high to request again.
//   The arbiter never samples req outside IDLE.
//  The loser's req stays pending; it is re-evaluated in the next IDLE with no loss.
//  rdata holds its value until that port's next read completes. Writes do not change rdata.
//  addr/write_data in IDLE: hold their last value (no glitching to 0).
//  ACCESS_CYCLES outside 1..4: elaboration $error.
// CONFIGURATION
//  SRAM_ARB_ROUND_ROBIN_EN defined: when both ports request, grant the port != last_grant;
//   last_grant updates on every grant.
//  Not defined: fixed priority, port 0 always wins; last_grant is unused but still reset.
// STRUCTURE
//  Package sram_arb_pkg: arb_state_t enum (IDLE, SETUP, ACCESS, CAPTURE, DONE);
//   constants KEY_ADDR=16'd0 and DATA_ADDR=16'd32.
//  Sub-module sram_arb_picker: combinational winner select from req[1:0] and last_grant,
//   implementing both macro variants.
//  Top holds the FSM, strobe counter, latched request and rdata registers.
// TESTING
//  1. m0 write to addr 0, wdata=128'hA5..A5 -> write=1 for 1 cycle with addr=0; m0_ack at N+4;
//     m1_ack stays 0.
//  2. m1 read at addr 32 while SRAM returns 128'h1234 -> read=1 for 1 cycle; m1_rdata=128'h1234
//     when m1_ack=1.
//  3. m0 and m1 request in the same cycle, 3 back-to-back rounds -> RR build: grants 0,1,0;
//     fixed build: 0,0,0 with m1 starved.
//  4. ACCESS_CYCLES=3, single read -> read high exactly 3 cycles; ack 2 cycles after read falls.
//  5. n_rst low during ACCESS -> all outputs at reset values immediately; after release,
//     a still-high req restarts from SETUP.
//  6. m0 holds req after ack -> second full access with no dropped cycles; busy low for exactly
//     1 IDLE cycle between the two accesses.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and well-known SRAM addresses for the test-SRAM access arbiter.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACCESS  = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } arb_state_t;

  localparam int NUM_PORTS = 2;

  // Fixed locations the AMBA side uses for the key and the data/result block.
  localparam logic [15:0] KEY_ADDR  = 16'd0;
  localparam logic [15:0] DATA_ADDR = 16'd32;

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Requester (m0 = AMBA slave side, m1 = cipher core) and SRAM signals of the arbiter.
// slave: the arbiter's view; master: requesters plus SRAM model.
interface sram_access_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 128
) ();
  logic              m0_req;
  logic              m0_wr;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_wr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              busy;
  logic              grant_id;

  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_wr, m1_addr, m1_wdata,
    output m1_ack, m1_rdata,
    output read, write, addr, write_data, busy, grant_id,
    input  read_data
  );

  modport master (
    output m0_req, m0_wr, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_wr, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata,
    input  read, write, addr, write_data, busy, grant_id,
    output read_data
  );
endinterface

// File: rtl/sram_arb_picker.sv
// Combinational winner select between the two SRAM requesters.
// SRAM_ARB_ROUND_ROBIN_EN: alternate on contention; otherwise port 0 has fixed priority.
module sram_arb_picker
  import sram_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 last_grant_i,
  output logic                 gnt_vld_o,
  output logic                 gnt_id_o
);
  assign gnt_vld_o = |req_i;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  assign gnt_id_o = (&req_i) ? ~last_grant_i : req_i[1];
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
  assign gnt_id_o = ~req_i[0];
`endif
endmodule

// File: rtl/sram_access_arbiter.sv
// Two-port arbiter for the single-port test SRAM: one whole access at a time,
// sequenced IDLE -> SETUP -> ACCESS -> CAPTURE -> DONE. Arbitration mode: SRAM_ARB_ROUND_ROBIN_EN.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 128,
  parameter int ACCESS_CYCLES = 1
) (
  input logic                  clk,
  input logic                  n_rst,
  sram_access_arbiter_if.slave bus
);
  if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 4) begin : g_cfg_chk
    $error("sram_access_arbiter: ACCESS_CYCLES must be within 1..4");
  end

  localparam logic [1:0] CNT_LAST = 2'(ACCESS_CYCLES - 1);

  arb_state_t                        state_q, state_d;
  logic [1:0]                        cnt_q, cnt_d;
  logic                              grant_q, grant_d;
  logic                              last_grant_q, last_grant_d;
  logic                              wr_q, wr_d;
  logic [ADDR_W-1:0]                 addr_q, addr_d;
  logic [DATA_W-1:0]                 wdata_q, wdata_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0]  rdata_q, rdata_d;
  logic                              pick_vld, pick_id;
  logic                              last_beat;

  sram_arb_picker u_picker (
    .req_i       ({bus.m1_req, bus.m0_req}),
    .last_grant_i(last_grant_q),
    .gnt_vld_o   (pick_vld),
    .gnt_id_o    (pick_id)
  );

  assign last_beat = (state_q == ACCESS) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (last_beat) state_d = CAPTURE;
      CAPTURE: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request is latched once in IDLE so requesters may change inputs mid-access.
  always_comb begin
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    if (state_q == IDLE && pick_vld) begin
      grant_d      = pick_id;
      last_grant_d = pick_id;
      wr_d         = pick_id ? bus.m1_wr    : bus.m0_wr;
      addr_d       = pick_id ? bus.m1_addr  : bus.m0_addr;
      wdata_d      = pick_id ? bus.m1_wdata : bus.m0_wdata;
    end
    if (state_q == SETUP)                  cnt_d = '0;
    else if (state_q == ACCESS && !last_beat) cnt_d = cnt_q + 2'd1;
    if (last_beat && !wr_q) rdata_d[grant_q] = bus.read_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q        <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  always_comb begin
    bus.read   = 1'b0;
    bus.write  = 1'b0;
    if (state_q == ACCESS) begin
      bus.read  = ~wr_q;
      bus.write = wr_q;
    end
    bus.busy   = (state_q != IDLE);
    bus.m0_ack = (state_q == DONE) & ~grant_q;
    bus.m1_ack = (state_q == DONE) &  grant_q;
  end

  assign bus.addr       = addr_q;
  assign bus.write_data = wdata_q;
  assign bus.m0_rdata   = rdata_q[0];
  assign bus.m1_rdata   = rdata_q[1];
  assign bus.grant_id   = grant_q;
endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter: two DUTs (ACCESS_CYCLES 1 and 3) against a
// timeline model that places every output by its offset from the grant edge.
module tb_sram_access_arbiter;
  import sram_arb_pkg::*;

  localparam int AW   = 16;
  localparam int DW   = 128;
  localparam int AC_A = 1;
  localparam int AC_B = 3;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  localparam logic [2:0] T3_SEQ = 3'b010;
`else
  localparam logic [2:0] T3_SEQ = 3'b000;
`endif

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  sram_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
  sram_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();

  sram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC_A)) dut_a (
    .clk(clk), .n_rst(n_rst), .bus(ifa));
  sram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC_B)) dut_b (
    .clk(clk), .n_rst(n_rst), .bus(ifb));

  // SRAM contents are a fixed function of the address.
  function automatic logic [DW-1:0] sram_word(input logic [AW-1:0] a);
    if (a == DATA_ADDR) return 128'h1234;
    return {8{a}};
  endfunction

  assign ifa.read_data = ifa.read ? sram_word(ifa.addr) : '0;
  assign ifb.read_data = ifb.read ? sram_word(ifb.addr) : '0;

  logic [1:0]    req_v [2];
  logic [1:0]    wr_v  [2];
  logic [AW-1:0] ad_v  [2][2];
  logic [DW-1:0] wd_v  [2][2];

  assign ifa.m0_req = req_v[0][0];  assign ifa.m1_req = req_v[0][1];
  assign ifa.m0_wr  = wr_v[0][0];   assign ifa.m1_wr  = wr_v[0][1];
  assign ifa.m0_addr = ad_v[0][0];  assign ifa.m1_addr = ad_v[0][1];
  assign ifa.m0_wdata = wd_v[0][0]; assign ifa.m1_wdata = wd_v[0][1];
  assign ifb.m0_req = req_v[1][0];  assign ifb.m1_req = req_v[1][1];
  assign ifb.m0_wr  = wr_v[1][0];   assign ifb.m1_wr  = wr_v[1][1];
  assign ifb.m0_addr = ad_v[1][0];  assign ifb.m1_addr = ad_v[1][1];
  assign ifb.m0_wdata = wd_v[1][0]; assign ifb.m1_wdata = wd_v[1][1];

  logic [1:0]    ack_o [2];
  logic          rds_o [2], wrs_o [2], busy_o [2], gid_o [2];
  logic [AW-1:0] adr_o [2];
  logic [DW-1:0] wdo_o [2];
  logic [DW-1:0] rdo_o [2][2];

  assign ack_o[0] = {ifa.m1_ack, ifa.m0_ack};  assign ack_o[1] = {ifb.m1_ack, ifb.m0_ack};
  assign rds_o[0] = ifa.read;   assign rds_o[1] = ifb.read;
  assign wrs_o[0] = ifa.write;  assign wrs_o[1] = ifb.write;
  assign busy_o[0] = ifa.busy;  assign busy_o[1] = ifb.busy;
  assign gid_o[0] = ifa.grant_id; assign gid_o[1] = ifb.grant_id;
  assign adr_o[0] = ifa.addr;   assign adr_o[1] = ifb.addr;
  assign wdo_o[0] = ifa.write_data; assign wdo_o[1] = ifb.write_data;
  assign rdo_o[0][0] = ifa.m0_rdata; assign rdo_o[0][1] = ifa.m1_rdata;
  assign rdo_o[1][0] = ifb.m0_rdata; assign rdo_o[1][1] = ifb.m1_rdata;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Model: an access occupies offsets 0 (setup), 1..AC (strobe), AC+1 (capture),
  // AC+2 (ack) after the grant edge; the arbiter is free again from offset AC+3.
  int            cyc = 0;
  int            g_m   [2];
  bit            act_m [2], w_m [2], wr_m [2], lg_m [2], gid_m [2];
  logic [AW-1:0] ad_m  [2];
  logic [DW-1:0] wd_m  [2];
  logic [DW-1:0] rd_m  [2][2];

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int u = 0; u < 2; u++) begin
        act_m[u] <= 1'b0; lg_m[u] <= 1'b1; gid_m[u] <= 1'b0; w_m[u] <= 1'b0;
        wr_m[u] <= 1'b0; ad_m[u] <= '0; wd_m[u] <= '0;
        rd_m[u][0] <= '0; rd_m[u][1] <= '0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        int ac, k;
        bit w;
        ac = (u == 1) ? AC_B : AC_A;
        k  = cyc - g_m[u];
        if (act_m[u] && k == ac && !wr_m[u]) rd_m[u][w_m[u]] <= sram_word(ad_m[u]);
        if ((!act_m[u] || k >= ac + 3) && req_v[u] != 2'b00) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
          w = (req_v[u] == 2'b11) ? !lg_m[u] : req_v[u][1];
`else
          w = !req_v[u][0];
`endif
          act_m[u] <= 1'b1; w_m[u] <= w; lg_m[u] <= w; gid_m[u] <= w;
          wr_m[u] <= wr_v[u][w]; ad_m[u] <= ad_v[u][w]; wd_m[u] <= wd_v[u][w];
          g_m[u] <= cyc + 1;
        end
      end
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      int ac, k;
      bit idle;
      logic [5:0] exp_c, got_c;
      ac   = (u == 1) ? AC_B : AC_A;
      k    = cyc - g_m[u];
      idle = !act_m[u] || k >= ac + 3;
      exp_c = {!idle,
               !idle && k >= 1 && k <= ac && !wr_m[u],
               !idle && k >= 1 && k <= ac &&  wr_m[u],
               !idle && k == ac + 2 &&  w_m[u],
               !idle && k == ac + 2 && !w_m[u],
               gid_m[u]};
      got_c = {busy_o[u], rds_o[u], wrs_o[u], ack_o[u], gid_o[u]};
      chk($sformatf("u%0d busy/rd/wr/ack1/ack0/gid", u), DW'(got_c), DW'(exp_c));
      chk($sformatf("u%0d addr", u), DW'(adr_o[u]), DW'(ad_m[u]));
      chk($sformatf("u%0d write_data", u), wdo_o[u], wd_m[u]);
      chk($sformatf("u%0d m0_rdata", u), rdo_o[u][0], rd_m[u][0]);
      chk($sformatf("u%0d m1_rdata", u), rdo_o[u][1], rd_m[u][1]);
    end
  end

  task automatic set_in(input int u, input int p, input logic wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_v[u][p] = wr; ad_v[u][p] = a; wd_v[u][p] = d; req_v[u][p] = 1'b1;
  endtask

  // Issue one access in an IDLE cycle and follow it to its ack (cycle counts from req).
  task automatic access(input int u, input int p, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int lat, output int strb,
                        output int last, output int oth);
    @(negedge clk);
    set_in(u, p, wr, a, d);
    lat = 0; strb = 0; last = 0; oth = 0;
    do begin
      @(negedge clk);
      lat++;
      if (rds_o[u] || wrs_o[u]) begin strb++; last = lat; end
      if (ack_o[u][1-p]) oth++;
    end while (!ack_o[u][p] && lat < 20);
    chk($sformatf("u%0d p%0d ack seen", u, p), DW'(ack_o[u][p]), DW'(1'b1));
    req_v[u][p] = 1'b0;
  endtask

  initial begin
    int lat, ns, last, oth, n, nack, gap, idl;
    logic [2:0] seq;
    for (int u = 0; u < 2; u++) begin
      req_v[u] = '0; wr_v[u] = '0;
      for (int p = 0; p < 2; p++) begin ad_v[u][p] = '0; wd_v[u][p] = '0; end
    end
    repeat (2) @(negedge clk);
    chk("reset busy", DW'(busy_o[0]), '0);
    chk("reset grant_id", DW'(gid_o[0]), '0);
    chk("reset addr", DW'(adr_o[0]), '0);
    n_rst = 1'b1;

    // m0 write of the key block
    access(0, 0, 1'b1, KEY_ADDR, {16{8'hA5}}, lat, ns, last, oth);
    chki("t1 ack latency", lat, 4);
    chki("t1 write cycles", ns, 1);
    chki("t1 m1 acks", oth, 0);
    chk("t1 write_data held", wdo_o[0], {16{8'hA5}});

    // m1 read of the data block
    access(0, 1, 1'b0, DATA_ADDR, '0, lat, ns, last, oth);
    chki("t2 read cycles", ns, 1);
    chk("t2 m1_rdata", rdo_o[0][1], 128'h1234);
    chk("t2 m0_rdata untouched", rdo_o[0][0], '0);

    // long strobe on the ACCESS_CYCLES=3 instance
    access(1, 0, 1'b0, 16'd5, '0, lat, ns, last, oth);
    chki("t4 ack latency", lat, 6);
    chki("t4 read cycles", ns, 3);
    chki("t4 ack after read falls", lat - last, 2);
    chk("t4 m0_rdata", rdo_o[1][0], {8{16'd5}});

    // simultaneous requests, three rounds
    @(negedge clk);
    set_in(0, 0, 1'b0, KEY_ADDR, '0);
    set_in(0, 1, 1'b0, DATA_ADDR, '0);
    n = 0; nack = 0; seq = '0;
    while (nack < 3 && n < 40) begin
      @(negedge clk);
      n++;
      if (ack_o[0] != 2'b00) begin seq[nack] = ack_o[0][1]; nack++; end
    end
    req_v[0] = 2'b00;
    chki("t3 grant count", nack, 3);
    chk("t3 grant order", DW'(seq), DW'(T3_SEQ));

    // m0 keeps req high across its ack
    @(negedge clk);
    set_in(0, 0, 1'b1, 16'd7, 128'h77);
    n = 0; nack = 0; gap = 0; idl = 0;
    while (nack < 2 && n < 30) begin
      @(negedge clk);
      n++;
      if (nack == 1) begin gap++; if (!busy_o[0]) idl++; end
      if (ack_o[0][0]) nack++;
    end
    req_v[0][0] = 1'b0;
    chki("t6 ack count", nack, 2);
    chki("t6 ack spacing", gap, 5);
    chki("t6 idle cycles", idl, 1);

    // reset in the middle of a read strobe
    @(negedge clk);
    set_in(0, 1, 1'b0, DATA_ADDR, '0);
    n = 0;
    while (!rds_o[0] && n < 10) begin @(negedge clk); n++; end
    chk("t5 strobe reached", DW'(rds_o[0]), DW'(1'b1));
    #2 n_rst = 1'b0;
    #1;
    chk("t5 rst busy", DW'(busy_o[0]), '0);
    chk("t5 rst read", DW'(rds_o[0]), '0);
    chk("t5 rst write", DW'(wrs_o[0]), '0);
    chk("t5 rst acks", DW'(ack_o[0]), '0);
    chk("t5 rst addr", DW'(adr_o[0]), '0);
    chk("t5 rst write_data", wdo_o[0], '0);
    chk("t5 rst m0_rdata", rdo_o[0][0], '0);
    chk("t5 rst m1_rdata", rdo_o[0][1], '0);
    chk("t5 rst grant_id", DW'(gid_o[0]), '0);
    @(negedge clk);
    #2 n_rst = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!ack_o[0][1] && lat < 20);
    chk("t5 restart ack", DW'(ack_o[0][1]), DW'(1'b1));
    chki("t5 restart latency", lat, 4);
    chk("t5 restart m1_rdata", rdo_o[0][1], 128'h1234);
    req_v[0][1] = 1'b0;

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
